// File: rtl/mult_div_unit_if.sv
// Issue-side bundle for the HI/LO multiply/divide unit: operands, MTHI/MTLO
// writes, and the busy/done/HI/LO results returned to the pipeline.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, hi_we, lo_we, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, hi_we, lo_we, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; result lands WIDTH+1 edges after start.
// One op in flight: busy stalls the issuer, and start/MTHI/MTLO are ignored while busy.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  mult_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // product upper half / partial remainder
  logic [WIDTH-1:0] aux_q, aux_d;     // multiplier bits / dividend->quotient bits
  logic [WIDTH-1:0] b_q, b_d;         // |multiplicand| / |divisor|
  logic [WIDTH-1:0] orig_rs_q, orig_rs_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;     // negate product or quotient
  logic             rneg_q, rneg_d;   // negate remainder
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             sgn;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   sum, shifted, diff;
  logic [2*WIDTH-1:0] prod, prod_neg;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      aux_q     <= '0;
      b_q       <= '0;
      orig_rs_q <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      aux_q     <= aux_d;
      b_q       <= b_d;
      orig_rs_q <= orig_rs_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = FIXUP;
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    aux_d     = aux_q;
    b_d       = b_q;
    orig_rs_d = orig_rs_q;
    div_d     = div_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    sgn   = ~bus.op[0];
    a_abs = (sgn && bus.rs_data[WIDTH-1]) ? (~bus.rs_data + ONE_W) : bus.rs_data;
    b_abs = (sgn && bus.rt_data[WIDTH-1]) ? (~bus.rt_data + ONE_W) : bus.rt_data;

    sum      = {1'b0, acc_q} + (aux_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    shifted  = {acc_q, aux_q[WIDTH-1]};
    diff     = shifted - {1'b0, b_q};
    prod     = {acc_q, aux_q};
    prod_neg = ~prod + ONE_2W;

    unique case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.wr_data;
        if (bus.lo_we) lo_d = bus.wr_data;
        if (bus.start) begin
          div_d     = bus.op[1];
          neg_d     = sgn & (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
          rneg_d    = sgn & bus.rs_data[WIDTH-1];
          orig_rs_d = bus.rs_data;
          acc_d     = '0;
          aux_d     = a_abs;
          b_d       = b_abs;
          cnt_d     = CW'(WIDTH-1);
        end
      end
      CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (!div_q) begin
          acc_d = sum[WIDTH:1];
          aux_d = {sum[0], aux_q[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
          acc_d = diff[WIDTH-1:0];
          aux_d = {aux_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          aux_d = {aux_q[WIDTH-2:0], 1'b0};
        end
      end
      FIXUP: begin
        done_d = 1'b1;
        if (!div_q) begin
          {hi_d, lo_d} = neg_q ? prod_neg : prod;
        end else if (b_q == '0) begin
          hi_d = orig_rs_q;
          lo_d = '1;
        end else begin
          lo_d = neg_q  ? (~aux_q + ONE_W) : aux_q;
          hi_d = rneg_q ? (~acc_q + ONE_W) : acc_q;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = done_q;
    bus.hi   = hi_q;
    bus.lo   = lo_q;
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed results, latency, idle/busy
// MTHI/MTLO behaviour and asynchronous reset mid-operation.
module tb_mult_div_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   lat;
  int   pulses;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge (E0); returns at the negedge after E0.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b;
    @(posedge clk); #1;
    chk("busy_after_start", bus.busy, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts edges from 'first' until done is seen; lat=-1 if it never comes.
  task automatic wait_done(input int first, output int l);
    l = -1;
    for (int n = first; n < first + 60; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        l = n;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int l;
    start_op(o, a, b);
    wait_done(1, l);
    chk({tag, "_latency"}, l, 33);
    chk({tag, "_busy_low"}, bus.busy, 1'b0);
    chk({tag, "_hi"}, bus.hi, ehi);
    chk({tag, "_lo"}, bus.lo, elo);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_data = '0; bus.rt_data = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_hi", bus.hi, 32'h0);
    chk("reset_lo", bus.lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle MTHI leaves LO alone
    @(negedge clk);
    bus.hi_we = 1'b1; bus.wr_data = 32'hDEAD;
    @(posedge clk); #1;
    chk("mthi_hi", bus.hi, 32'hDEAD);
    chk("mthi_lo", bus.lo, 32'h0);
    @(negedge clk);
    bus.hi_we = 1'b0;

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    chk("done_one_cycle_pre", bus.done, 1'b1);
    @(posedge clk); #1;
    chk("done_one_cycle", bus.done, 1'b0);
    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_negneg", 2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negdivisor", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_zero", 2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // Start and MT write while busy are ignored; HI/LO hold during CALC
    @(negedge clk);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'h1111;
    @(posedge clk); #1;
    chk("mt_both_hi", bus.hi, 32'h1111);
    chk("mt_both_lo", bus.lo, 32'h1111);
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    start_op(2'b01, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.rs_data = 32'd50; bus.rt_data = 32'd9;
    bus.hi_we = 1'b1; bus.wr_data = 32'hAA;
    @(posedge clk); #1;
    chk("busy_e10", bus.busy, 1'b1);
    chk("hold_hi_e10", bus.hi, 32'h1111);
    chk("hold_lo_e10", bus.lo, 32'h1111);
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    wait_done(11, lat);
    chk("ignored_latency", lat, 33);
    chk("ignored_hi", bus.hi, 32'h0);
    chk("ignored_lo", bus.lo, 32'd15);
    @(posedge clk); #1;
    chk("no_queued_op", bus.busy, 1'b0);

    // MT in the start cycle lands at E0, op result overwrites it later
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.rs_data = 32'd2; bus.rt_data = 32'd3;
    bus.lo_we = 1'b1; bus.wr_data = 32'h77;
    @(posedge clk); #1;
    chk("start_mt_lo_e0", bus.lo, 32'h77);
    @(negedge clk);
    bus.start = 1'b0; bus.lo_we = 1'b0;
    wait_done(1, lat);
    chk("start_mt_latency", lat, 33);
    chk("start_mt_lo_final", bus.lo, 32'd6);

    // Reset mid-operation
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
    bus.hi_we = 1'b1; bus.wr_data = 32'h55;
    @(posedge clk); #1;
    chk("rst_pre_hi", bus.hi, 32'h55);
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_hi", bus.hi, 32'h0);
    chk("midrst_lo", bus.lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    chk("midrst_idle", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
